// File: rtl/alu_ctrl_pipe.sv
`default_nettype none
// ==== alu_ctrl_pipe : 2-stage ALU-control decoder with ready/valid and illegal counter ====
// ==== rev 1.0 | optional macro ALU_CTRL_SHIFT_EN adds LSL/LSR decode                  ====
module alu_ctrl_pipe #(
  parameter int OPC_W  = 11,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [OPC_W-1:0]  opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam logic [10:0] c_OPC_ADD = 11'b10001011000;
  localparam logic [10:0] c_OPC_SUB = 11'b11001011000;
  localparam logic [10:0] c_OPC_AND = 11'b10001010000;
  localparam logic [10:0] c_OPC_ORR = 11'b10101010000;
`ifdef ALU_CTRL_SHIFT_EN
  localparam logic [10:0] c_OPC_LSL = 11'b11010011011;
  localparam logic [10:0] c_OPC_LSR = 11'b11010011010;
`endif

  logic [10:0]      w_rop;
  logic [3:0]       w_ctrl;
  logic             w_ill;
  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_out_xfer;

  logic             r_s1_valid;
  logic [3:0]       r_s1_ctrl;
  logic             r_s1_ill;
  logic             r_s2_valid;
  logic [3:0]       r_s2_ctrl;
  logic             r_s2_ill;
  logic [CNT_W-1:0] r_cnt;

  assign w_rop = opcode[OPC_W-1 -: 11];

  always_comb begin
    w_ctrl = 4'b0000;
    w_ill  = 1'b0;
    case (alu_op)
      2'b00: w_ctrl = 4'b0010;
      2'b01: w_ctrl = 4'b0111;
      2'b10: begin
        case (w_rop)
          c_OPC_ADD: w_ctrl = 4'b0010;
          c_OPC_SUB: w_ctrl = 4'b0110;
          c_OPC_AND: w_ctrl = 4'b0000;
          c_OPC_ORR: w_ctrl = 4'b0001;
`ifdef ALU_CTRL_SHIFT_EN
          c_OPC_LSL: w_ctrl = 4'b0011;
          c_OPC_LSR: w_ctrl = 4'b0100;
`endif
          default:   w_ill  = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
  end

  // S1 may refill in the same cycle its entry advances into S2
  assign w_s2_load  = !r_s2_valid || out_ready;
  assign w_s1_load  = !r_s1_valid || w_s2_load;
  assign in_ready   = rst_n && w_s1_load;
  assign w_out_xfer = r_s2_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_ctrl  <= 4'b0000;
      r_s1_ill   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_ctrl  <= 4'b0000;
      r_s2_ill   <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_ctrl <= r_s1_ctrl;
          r_s2_ill  <= r_s1_ill;
        end
      end
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_ctrl <= w_ctrl;
          r_s1_ill  <= w_ill;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      r_cnt <= '0;
    end else if (w_out_xfer && r_s2_ill && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid   = r_s2_valid;
  assign alu_ctrl    = CTRL_W'(r_s2_ctrl);
  assign illegal     = r_s2_ill;
  assign illegal_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_pipe.sv
`default_nettype none
// ==== tb_alu_ctrl_pipe : directed + randomized check against a queue-based reference model ====
// ==== rev 1.0                                                                               ====
module tb_alu_ctrl_pipe;

  localparam int c_OPC_W  = 11;
  localparam int c_CTRL_W = 4;
  localparam int c_CNT_W  = 2;
  localparam int c_CNT_MAX = (1 << c_CNT_W) - 1;

  localparam logic [10:0] c_ADD = 11'b10001011000;
  localparam logic [10:0] c_SUB = 11'b11001011000;
  localparam logic [10:0] c_AND = 11'b10001010000;
  localparam logic [10:0] c_ORR = 11'b10101010000;
  localparam logic [10:0] c_LSL = 11'b11010011011;
  localparam logic [10:0] c_LSR = 11'b11010011010;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          alu_op;
  logic [c_OPC_W-1:0]  opcode;
  logic                out_valid;
  logic                out_ready;
  logic [c_CTRL_W-1:0] alu_ctrl;
  logic                illegal;
  logic                cnt_clr;
  logic [c_CNT_W-1:0]  illegal_cnt;

  int  n_vec  = 0;
  int  n_miss = 0;
  bit  chk_en = 1'b0;
  bit  last_rst = 1'b1;

  logic [4:0] q_res[$];
  int         q_age[$];
  int         m_cnt = 0;

  always #5 clk = ~clk;

  alu_ctrl_pipe #(.OPC_W(c_OPC_W), .CTRL_W(c_CTRL_W), .CNT_W(c_CNT_W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .opcode     (opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_ctrl   (alu_ctrl),
    .illegal    (illegal),
    .cnt_clr    (cnt_clr),
    .illegal_cnt(illegal_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference decode: {illegal, ctrl}
  function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [10:0] opc);
    if (op == 2'd0) return {1'b0, 4'd2};
    if (op == 2'd1) return {1'b0, 4'd7};
    if (op == 2'd3) return {1'b1, 4'd0};
    if (opc == c_ADD) return {1'b0, 4'd2};
    if (opc == c_SUB) return {1'b0, 4'd6};
    if (opc == c_AND) return {1'b0, 4'd0};
    if (opc == c_ORR) return {1'b0, 4'd1};
`ifdef ALU_CTRL_SHIFT_EN
    if (opc == c_LSL) return {1'b0, 4'd3};
    if (opc == c_LSR) return {1'b0, 4'd4};
`endif
    return {1'b1, 4'd0};
  endfunction

  // Head of queue is visible once it has seen one edge; capacity is two entries.
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_rdy, exp_ov, dlv;
      exp_rdy = rst_n && ((q_res.size() < 2) || out_ready);
      exp_ov  = (q_res.size() > 0) && (q_age[0] >= 1);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
      if (exp_ov) begin
        chk("alu_ctrl", 32'(alu_ctrl), 32'(q_res[0][3:0]));
        chk("illegal", 32'(illegal), 32'(q_res[0][4]));
      end else if (last_rst) begin
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
      end
      last_rst = !rst_n;
      if (!rst_n) begin
        q_res.delete();
        q_age.delete();
        m_cnt = 0;
      end else begin
        dlv = exp_ov && out_ready;
        if (dlv) begin
          if (q_res[0][4] && m_cnt < c_CNT_MAX) m_cnt++;
          void'(q_res.pop_front());
          void'(q_age.pop_front());
        end
        if (cnt_clr) m_cnt = 0;
        for (int i = 0; i < q_age.size(); i++) q_age[i]++;
        if (in_valid && exp_rdy) begin
          q_res.push_back(ref_dec(alu_op, opcode));
          q_age.push_back(0);
        end
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [1:0] op,
                      input logic [10:0] opc, input logic ordy, input logic clr);
    rst_n = r; in_valid = v; alu_op = op; opcode = opc; out_ready = ordy; cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'd0, 11'd0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [10:0] tbl[6];
    tbl[0] = c_ADD; tbl[1] = c_SUB; tbl[2] = c_AND;
    tbl[3] = c_ORR; tbl[4] = c_LSL; tbl[5] = c_LSR;

    rst_n = 1'b0; in_valid = 1'b0; alu_op = 2'd0; opcode = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0, 11'd0, 1'b1, 1'b0);

    step(1'b1, 1'b1, 2'd2, c_SUB, 1'b1, 1'b0);
    idle(3);

    step(1'b1, 1'b1, 2'd2, c_ADD, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'd2, c_AND, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'd2, c_ORR, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'd0, 11'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'd1, 11'd0, 1'b1, 1'b0);
    idle(3);

    step(1'b1, 1'b1, 2'd2, c_SUB, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd1, 11'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd2, c_ORR, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd2, c_ORR, 1'b0, 1'b0);
    idle(4);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2'd3, 11'd0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 2'd3, 11'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd0, 11'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd0, 11'd0, 1'b1, 1'b1);
    idle(2);

    step(1'b1, 1'b1, 2'd2, c_LSL, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'd2, c_LSR, 1'b1, 1'b0);
    idle(3);

    step(1'b1, 1'b1, 2'd2, c_ADD, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd3, 11'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd2, c_AND, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd2, c_AND, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 11'd0, 1'b1, 1'b0);
    idle(4);

    for (int i = 0; i < 3000; i++) begin
      logic [10:0] opc;
      if ($urandom_range(0, 3) == 0) opc = 11'($urandom);
      else opc = tbl[$urandom_range(0, 5)];
      step(($urandom_range(0, 99) >= 2),
           ($urandom_range(0, 99) < 70),
           2'($urandom_range(0, 3)),
           opc,
           ($urandom_range(0, 99) < 65),
           ($urandom_range(0, 99) < 3));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_pipe.md
ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
- REQ-001: Parameter OPC_W, default 11: opcode field width; SHALL be >= 11, decode uses opcode[OPC_W-1 -: 11].
- REQ-002: Parameter CTRL_W, default 4: alu_ctrl width; SHALL be >= 4, 4-bit code zero-extended into upper bits.
- REQ-003: Parameter CNT_W, default 8: illegal_cnt width.
- REQ-004: clk  input  1  single clock; all state updates on rising edge.
- REQ-005: rst_n  input  1  reset, synchronous, active-low.
- REQ-006: in_valid  input  1  upstream request valid.
- REQ-007: in_ready  output  1  block accepts request this cycle.
- REQ-008: alu_op  input  2  main-control ALUOp.
- REQ-009: opcode  input  OPC_W  instruction opcode field.
- REQ-010: out_valid  output  1  result valid.
- REQ-011: out_ready  input  1  downstream accepts result.
- REQ-012: alu_ctrl  output  CTRL_W  ALU operation code.
- REQ-013: illegal  output  1  result corresponds to undecodable request.
- REQ-014: cnt_clr  input  1  synchronous clear of illegal_cnt.
- REQ-015: illegal_cnt  output  CNT_W  saturating count of illegal results delivered.

Function
- REQ-016: Decode SHALL be: alu_op 00 -> 0010; 01 -> 0111; 11 -> illegal; 10 -> R-type table on opcode[OPC_W-1 -: 11].
- REQ-017: R-type table SHALL be: 10001011000 ADD -> 0010; 11001011000 SUB -> 0110; 10001010000 AND -> 0000; 10101010000 ORR -> 0001.
- REQ-018: Unmatched R-type opcode or alu_op 11 SHALL produce alu_ctrl 0 and illegal 1; every legal decode SHALL produce illegal 0.
- REQ-019: Pipeline SHALL have two register stages: S1 (decoded result) and S2 (output register driving out_valid/alu_ctrl/illegal).
- REQ-020: Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
- REQ-021: S2 SHALL load from S1 when S2 empty or out_ready=1; S1 SHALL load from input when S1 empty or S1 moves to S2.
- REQ-022: in_ready SHALL equal !s1_valid || !out_valid || out_ready (combinational out_ready path permitted).
- REQ-023: Latency SHALL be 2 cycles from input transfer to out_valid with out_ready held 1; throughput 1 per cycle.
- REQ-024: While out_valid && !out_ready, alu_ctrl and illegal SHALL hold stable; with both stages full, in_ready SHALL be 0 and no request lost or duplicated.
- REQ-025: Results SHALL emerge in request order.
- REQ-026: illegal_cnt SHALL increment by 1 on each output transfer with illegal=1, saturating at 2^CNT_W-1.
- REQ-027: cnt_clr=1 SHALL set illegal_cnt to 0 next cycle, overriding a simultaneous increment.

Reset
- REQ-028: While rst_n=0 at a rising edge: S1/S2 valid cleared, alu_ctrl=0, illegal=0, illegal_cnt=0.
- REQ-029: in_ready SHALL be 0 while rst_n=0; 1 on first cycle after release.
- REQ-030: Reset mid-operation SHALL discard all in-flight entries; no output transfer for them.

Configuration
- REQ-031: Macro ALU_CTRL_SHIFT_EN defined: R-type table adds 11010011011 LSL -> 0011 and 11010011010 LSR -> 0100.
- REQ-032: ALU_CTRL_SHIFT_EN undefined: those opcodes SHALL decode illegal per REQ-018.

Verification
- REQ-033: Reset, then alu_op=10, opcode=11001011000, out_ready=1 -> out_valid at cycle 2, alu_ctrl=0110, illegal=0.
- REQ-034: Back-to-back ADD, AND, ORR, alu_op=00, alu_op=01, out_ready=1 -> consecutive outputs 0010,0000,0001,0010,0111, in order, no bubbles.
- REQ-035: Fill both stages with out_ready=0 -> in_ready=0, output held; release out_ready -> all results delivered once, in order.
- REQ-036: CNT_W=2, five alu_op=11 requests delivered -> illegal=1 each, illegal_cnt 1,2,3,3,3; cnt_clr with simultaneous illegal transfer -> 0.
- REQ-037: opcode 11010011011 with alu_op=10 -> alu_ctrl=0011, illegal=0 if ALU_CTRL_SHIFT_EN, else alu_ctrl=0000, illegal=1.
- REQ-038: rst_n=0 with both stages full -> next cycle out_valid=0, in_ready=0; after release no stale results appear.
